// File: rtl/frame_mem_port_scheduler_if.sv
// Bundle of the receiver, scanout and frame-memory signals around frame_mem_port_scheduler.
// master = environment (receiver, scanout, RAM model); slave = the scheduler.
interface frame_mem_port_scheduler_if #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              IwWrReq;
    logic [ADDR_W-1:0] IbWrAddr;
    logic [DATA_W-1:0] IbWrData;
    logic [LVL_W-1:0]  ObFifoLevel;
    logic              OwOverflow;
    logic              IwRdReq;
    logic [ADDR_W-1:0] IbRdAddr;
    logic [DATA_W-1:0] ObRdData;
    logic              OwRdValid;
    logic              IwClearReq;
    logic [DATA_W-1:0] IbClearColor;
    logic              OwClearBusy;
    logic [ADDR_W-1:0] ObMemAddr;
    logic [DATA_W-1:0] ObMemWData;
    logic              OwMemWE;
    logic              OwMemRE;
    logic [DATA_W-1:0] IbMemRData;

    modport master (
        output IwWrReq, IbWrAddr, IbWrData, IwRdReq, IbRdAddr,
               IwClearReq, IbClearColor, IbMemRData,
        input  ObFifoLevel, OwOverflow, ObRdData, OwRdValid, OwClearBusy,
               ObMemAddr, ObMemWData, OwMemWE, OwMemRE
    );

    modport slave (
        input  IwWrReq, IbWrAddr, IbWrData, IwRdReq, IbRdAddr,
               IwClearReq, IbClearColor, IbMemRData,
        output ObFifoLevel, OwOverflow, ObRdData, OwRdValid, OwClearBusy,
               ObMemAddr, ObMemWData, OwMemWE, OwMemRE
    );
endinterface

// File: rtl/frame_mem_port_scheduler.sv
// Single-port frame memory owner: scanout reads > buffered pixel writes > frame fill.
// Optional fill engine built only when FRAME_FILL_EN is defined.
module frame_mem_port_scheduler #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int FB_PIXELS  = 38400
) (
    input  logic IwClk,
    input  logic IwRstn,
    frame_mem_port_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FB_PIXELS - 1);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d, mem_re_q, mem_re_d;
    logic              rd_pend_q, rd_pend_d, rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              clear_busy_q, clear_busy_d;

    logic              full, empty, push, pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              fill_active;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;

    assign full      = (level_q == FULL_LVL);
    assign empty     = (level_q == '0);
    assign head_addr = fifo_addr_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];
    assign push      = bus.IwWrReq && !full;
    // The FIFO is frozen while the fill owns the write slot.
    assign pop       = !bus.IwRdReq && !fill_active && !empty;

`ifdef FRAME_FILL_EN
    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FILL} state_e;

    state_e            state_q, state_d;
    logic [15:0]       fill_cnt_q, fill_cnt_d;
    logic [DATA_W-1:0] color_q, color_d;

    assign fill_active = (state_q == S_FILL);
    assign fill_addr   = ADDR_W'(fill_cnt_q);
    assign fill_data   = color_q;

    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        color_d      = color_q;
        clear_busy_d = clear_busy_q;
        unique case (state_q)
            S_IDLE: if (bus.IwClearReq) begin
                state_d      = S_DRAIN;
                color_d      = bus.IbClearColor;
                fill_cnt_d   = '0;
                clear_busy_d = 1'b1;
            end
            S_DRAIN: if (empty) state_d = S_FILL;
            S_FILL: if (!bus.IwRdReq) begin
                if (fill_addr == LAST_PIX) begin
                    state_d      = S_IDLE;
                    fill_cnt_d   = '0;
                    clear_busy_d = 1'b0;
                end else begin
                    fill_cnt_d = fill_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge IwClk or negedge IwRstn) begin
        if (!IwRstn) begin
            state_q    <= S_IDLE;
            fill_cnt_q <= '0;
            color_q    <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            color_q    <= color_d;
        end
    end
`else
    logic unused_clear;

    assign fill_active  = 1'b0;
    assign fill_addr    = '0;
    assign fill_data    = '0;
    assign clear_busy_d = 1'b0;
    assign unused_clear = ^{bus.IwClearReq, bus.IbClearColor};
`endif

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
        overflow_d  = overflow_q | (bus.IwWrReq && full);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        if (bus.IwRdReq) begin
            mem_re_d   = 1'b1;
            mem_addr_d = bus.IbRdAddr;
        end else if (pop) begin
            // Out-of-range entries are consumed silently.
            if (head_addr <= LAST_PIX) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = head_addr;
                mem_wdata_d = head_data;
            end
        end else if (fill_active) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = fill_addr;
            mem_wdata_d = fill_data;
        end
        // RAM returns data one cycle after RE; capture it one cycle later still.
        rd_pend_d  = mem_re_q;
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_pend_q ? bus.IbMemRData : rd_data_q;
    end

    always_ff @(posedge IwClk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.IbWrAddr;
            fifo_data_q[wr_ptr_q] <= bus.IbWrData;
        end
    end

    always_ff @(posedge IwClk or negedge IwRstn) begin
        if (!IwRstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            clear_busy_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            rd_pend_q    <= rd_pend_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            clear_busy_q <= clear_busy_d;
        end
    end

    assign bus.ObFifoLevel = level_q;
    assign bus.OwOverflow  = overflow_q;
    assign bus.ObRdData    = rd_data_q;
    assign bus.OwRdValid   = rd_valid_q;
    assign bus.OwClearBusy = clear_busy_q;
    assign bus.ObMemAddr   = mem_addr_q;
    assign bus.ObMemWData  = mem_wdata_q;
    assign bus.OwMemWE     = mem_we_q;
    assign bus.OwMemRE     = mem_re_q;
endmodule

// File: tb/tb_frame_mem_port_scheduler.sv
// Directed bench for frame_mem_port_scheduler; RAM model returns addr^0x5A5A and logs writes.
module tb_frame_mem_port_scheduler;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int FB_PIXELS  = 38400;

    logic IwClk  = 1'b0;
    logic IwRstn = 1'b0;
    int   total  = 0;
    int   bad    = 0;
    logic [31:0] wr_log[$];

    always #5 IwClk = ~IwClk;

    frame_mem_port_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus();

    frame_mem_port_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .FB_PIXELS(FB_PIXELS)
    ) dut (
        .IwClk (IwClk),
        .IwRstn(IwRstn),
        .bus   (bus)
    );

    always @(posedge IwClk) begin
        if (bus.OwMemRE) bus.IbMemRData <= bus.ObMemAddr ^ 16'h5A5A;
        if (IwRstn && bus.OwMemWE) wr_log.push_back({bus.ObMemAddr, bus.ObMemWData});
    end

    task automatic tick;
        @(posedge IwClk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.IwWrReq      = 1'b0;
        bus.IbWrAddr     = '0;
        bus.IbWrData     = '0;
        bus.IwRdReq      = 1'b0;
        bus.IbRdAddr     = '0;
        bus.IwClearReq   = 1'b0;
        bus.IbClearColor = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        IwRstn = 1'b0;
        #3;
        IwRstn = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        tick();
        bus.IwRdReq = 1'b1;
        bus.IwWrReq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.IbWrAddr = 16'(16'h0020 + i);
            bus.IbWrData = 16'(16'h0A00 + i);
            tick();
        end
        bus.IwWrReq = 1'b0;
        total++;
        if (bus.ObFifoLevel !== 4'd3) begin bad++; $display("FAIL reset_prefill: level got %0d want 3", bus.ObFifoLevel); end
        IwRstn = 1'b0;
        #2;
        total++;
        if (bus.ObFifoLevel !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", bus.ObFifoLevel); end
        total++;
        if (bus.OwMemWE !== 1'b0 || bus.OwMemRE !== 1'b0) begin bad++; $display("FAIL reset_we_re: got we=%b re=%b want 0 0", bus.OwMemWE, bus.OwMemRE); end
        total++;
        if (bus.OwOverflow !== 1'b0 || bus.OwRdValid !== 1'b0 || bus.OwClearBusy !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got ovf=%b vld=%b busy=%b want 0 0 0", bus.OwOverflow, bus.OwRdValid, bus.OwClearBusy);
        end
        total++;
        if (bus.ObMemAddr !== 16'h0 || bus.ObRdData !== 16'h0) begin bad++; $display("FAIL reset_busses: got addr=%h rdata=%h want 0 0", bus.ObMemAddr, bus.ObRdData); end
        idle_inputs();
        #1;
        IwRstn = 1'b1;
        wr_log.delete();
        repeat (6) tick();
        total++;
        if (wr_log.size() != 0) begin bad++; $display("FAIL reset_no_write: got %0d writes want 0", wr_log.size()); end
    endtask

    task automatic test_single_write;
        wr_log.delete();
        bus.IwWrReq  = 1'b1;
        bus.IbWrAddr = 16'h0010;
        bus.IbWrData = 16'h7FFF;
        tick();
        bus.IwWrReq = 1'b0;
        total++;
        if (bus.ObFifoLevel !== 4'd1 || bus.OwMemWE !== 1'b0) begin bad++; $display("FAIL push_edge: got level=%0d we=%b want 1 0", bus.ObFifoLevel, bus.OwMemWE); end
        tick();
        total++;
        if (bus.OwMemWE !== 1'b1 || bus.ObMemAddr !== 16'h0010 || bus.ObMemWData !== 16'h7FFF) begin
            bad++; $display("FAIL write_issue: got we=%b addr=%h data=%h want 1 0010 7fff", bus.OwMemWE, bus.ObMemAddr, bus.ObMemWData);
        end
        total++;
        if (bus.ObFifoLevel !== 4'd0) begin bad++; $display("FAIL write_pop: level got %0d want 0", bus.ObFifoLevel); end
        bus.IwWrReq  = 1'b1;
        bus.IbWrAddr = 16'h9600;
        bus.IbWrData = 16'h1234;
        tick();
        bus.IwWrReq = 1'b0;
        tick();
        total++;
        if (bus.OwMemWE !== 1'b0 || bus.ObFifoLevel !== 4'd0 || bus.ObMemAddr !== 16'h0010) begin
            bad++; $display("FAIL out_of_range: got we=%b level=%0d addr=%h want 0 0 0010", bus.OwMemWE, bus.ObFifoLevel, bus.ObMemAddr);
        end
        tick();
        total++;
        if (wr_log.size() != 1) begin bad++; $display("FAIL single_count: got %0d writes want 1", wr_log.size()); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_rd;
        wr_log.delete();
        for (int c = 0; c < 14; c++) begin
            bus.IwRdReq  = (c < 12);
            bus.IbRdAddr = 16'(16'h0100 + c);
            bus.IwWrReq  = (c < 10);
            bus.IbWrAddr = 16'(16'h0200 + c);
            bus.IbWrData = 16'(16'h1000 + c);
            tick();
            if (c < 12) begin
                total++;
                if (bus.OwMemRE !== 1'b1 || bus.ObMemAddr !== 16'(16'h0100 + c)) begin
                    bad++; $display("FAIL rd_issue c=%0d: got re=%b addr=%h want 1 %h", c, bus.OwMemRE, bus.ObMemAddr, 16'(16'h0100 + c));
                end
            end
            if (c >= 2) begin
                exp_rd = 16'(16'h0100 + c - 2) ^ 16'h5A5A;
                total++;
                if (bus.OwRdValid !== 1'b1 || bus.ObRdData !== exp_rd) begin
                    bad++; $display("FAIL rd_data c=%0d: got vld=%b data=%h want 1 %h", c, bus.OwRdValid, bus.ObRdData, exp_rd);
                end
            end
            if (c == 11) begin
                total++;
                if (bus.ObFifoLevel !== 4'd8 || bus.OwOverflow !== 1'b1 || wr_log.size() != 0) begin
                    bad++; $display("FAIL starve_full: got level=%0d ovf=%b writes=%0d want 8 1 0", bus.ObFifoLevel, bus.OwOverflow, wr_log.size());
                end
            end
        end
        idle_inputs();
        tick();
        total++;
        if (bus.OwRdValid !== 1'b0) begin bad++; $display("FAIL rd_valid_pulse: got %b want 0", bus.OwRdValid); end
        repeat (10) tick();
        total++;
        if (wr_log.size() != 8) begin
            bad++; $display("FAIL drain_count: got %0d writes want 8", wr_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (wr_log[i] !== {16'(16'h0200 + i), 16'(16'h1000 + i)}) begin
                    bad++; $display("FAIL drain_order i=%0d: got %h want %h", i, wr_log[i], {16'(16'h0200 + i), 16'(16'h1000 + i)});
                end
            end
        end
    endtask

    task automatic test_full_pop;
        do_reset();
        tick();
        wr_log.delete();
        bus.IwRdReq = 1'b1;
        bus.IwWrReq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.IbWrAddr = 16'(16'h0040 + i);
            bus.IbWrData = 16'(16'h2000 + i);
            tick();
        end
        total++;
        if (bus.ObFifoLevel !== 4'd8 || bus.OwOverflow !== 1'b0) begin
            bad++; $display("FAIL full_prefill: got level=%0d ovf=%b want 8 0", bus.ObFifoLevel, bus.OwOverflow);
        end
        bus.IwRdReq  = 1'b0;
        bus.IbWrAddr = 16'h0300;
        bus.IbWrData = 16'hDEAD;
        tick();
        bus.IwWrReq = 1'b0;
        total++;
        if (bus.ObFifoLevel !== 4'd7 || bus.OwOverflow !== 1'b1) begin
            bad++; $display("FAIL full_pop_drop: got level=%0d ovf=%b want 7 1", bus.ObFifoLevel, bus.OwOverflow);
        end
        total++;
        if (bus.OwMemWE !== 1'b1 || bus.ObMemAddr !== 16'h0040) begin
            bad++; $display("FAIL full_pop_head: got we=%b addr=%h want 1 0040", bus.OwMemWE, bus.ObMemAddr);
        end
        repeat (10) tick();
        total++;
        if (wr_log.size() != 8 || wr_log[7] !== {16'h0047, 16'h2007} || bus.OwOverflow !== 1'b1) begin
            bad++; $display("FAIL full_drain: got writes=%0d ovf=%b want 8 1", wr_log.size(), bus.OwOverflow);
        end
    endtask

`ifdef FRAME_FILL_EN
    task automatic test_fill;
        int n;
        int errs;
        bit done;
        do_reset();
        tick();
        wr_log.delete();
        bus.IwRdReq  = 1'b1;
        bus.IwWrReq  = 1'b1;
        bus.IbWrAddr = 16'h0100; bus.IbWrData = 16'h1111; tick();
        bus.IbWrAddr = 16'h0101; bus.IbWrData = 16'h2222; tick();
        bus.IwWrReq      = 1'b0;
        bus.IwRdReq      = 1'b0;
        bus.IwClearReq   = 1'b1;
        bus.IbClearColor = 16'h001F;
        tick();
        bus.IwClearReq = 1'b0;
        total++;
        if (bus.OwClearBusy !== 1'b1) begin bad++; $display("FAIL fill_busy_rise: got %b want 1", bus.OwClearBusy); end
        done = 1'b0;
        for (n = 0; n < 40000 && !done; n++) begin
            if (n == 1000) begin
                bus.IwWrReq      = 1'b1;
                bus.IbWrAddr     = 16'h0005;
                bus.IbWrData     = 16'hABCD;
                bus.IwClearReq   = 1'b1;
                bus.IbClearColor = 16'h7C00;
            end else begin
                bus.IwWrReq    = 1'b0;
                bus.IwClearReq = 1'b0;
            end
            tick();
            if (bus.OwClearBusy === 1'b0) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL fill_timeout: busy still %b after %0d cycles", bus.OwClearBusy, n);
        end else begin
            total++;
            if (bus.OwMemWE !== 1'b1 || bus.ObMemAddr !== 16'(FB_PIXELS - 1) || bus.ObMemWData !== 16'h001F) begin
                bad++; $display("FAIL fill_last: got we=%b addr=%h data=%h want 1 95ff 001f", bus.OwMemWE, bus.ObMemAddr, bus.ObMemWData);
            end
        end
        idle_inputs();
        repeat (5) tick();
        total++;
        if (wr_log.size() != FB_PIXELS + 3) begin
            bad++; $display("FAIL fill_count: got %0d writes want %0d", wr_log.size(), FB_PIXELS + 3);
        end else begin
            total++;
            if (wr_log[0] !== {16'h0100, 16'h1111} || wr_log[1] !== {16'h0101, 16'h2222}) begin
                bad++; $display("FAIL fill_predrain: got %h %h want 01001111 01012222", wr_log[0], wr_log[1]);
            end
            errs = 0;
            for (int i = 0; i < FB_PIXELS; i++)
                if (wr_log[i + 2] !== {16'(i), 16'h001F}) errs++;
            total++;
            if (errs != 0) begin bad++; $display("FAIL fill_body: got %0d bad fill writes want 0", errs); end
            total++;
            if (wr_log[FB_PIXELS + 2] !== {16'h0005, 16'hABCD}) begin
                bad++; $display("FAIL fill_post_push: got %h want 0005abcd", wr_log[FB_PIXELS + 2]);
            end
        end
        total++;
        if (bus.OwClearBusy !== 1'b0) begin bad++; $display("FAIL fill_busy_end: got %b want 0", bus.OwClearBusy); end
    endtask
`else
    task automatic test_fill_disabled;
        wr_log.delete();
        bus.IwClearReq   = 1'b1;
        bus.IbClearColor = 16'h001F;
        tick();
        bus.IwClearReq = 1'b0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (bus.OwClearBusy !== 1'b0 || bus.OwMemWE !== 1'b0) begin
                bad++; $display("FAIL nofill_idle i=%0d: got busy=%b we=%b want 0 0", i, bus.OwClearBusy, bus.OwMemWE);
            end
            tick();
        end
        total++;
        if (wr_log.size() != 0) begin bad++; $display("FAIL nofill_writes: got %0d want 0", wr_log.size()); end
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_back_to_back();
        test_full_pop();
`ifdef FRAME_FILL_EN
        test_fill();
`else
        test_fill_disabled();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
